// File: rtl/tile_pixel_serializer.sv
// tile_pixel_serializer
//   Final stage of a scroll plane: takes one 8-pixel tile row per tile from the
//   GFX ROM, double-buffers it and shifts one pixel out per pixel-clock enable,
//   applying a 0..7 pixel fine horizontal scroll across the tile boundary.
//
//   Optional feature: define TILE_HFLIP_EN to honour the per-tile flip-X bit
//   (COL[1]) when FLIPX_EN is high. Without it the flip bit is not stored and
//   FLIPX_EN is ignored.
//
// Ports
//   clk_24M   system clock
//   RES       asynchronous active-high reset
//   PIX_CE    pixel-clock enable, one clk_24M cycle wide
//   HRST      line start: clears the pixel phase, suppresses the tile transfer
//   LOAD      ROM_D/COL/Z valid, captured into the staging buffer
//   ROM_D     tile row, pixel k = ROM_D[31-4k -: 4], k=0 leftmost
//   COL       tile attribute: [7:4] palette, [1] flip-X request
//   Z         fine horizontal scroll for this tile
//   FLIPX_EN  global enable for COL[1] flip (TILE_HFLIP_EN builds only)
//   BLANK     force output to zero
//   DOUT      {palette, colour index}, registered
//   TRANSP    colour index is zero or BLANK, registered

module tile_pixel_serializer #(
    parameter int PIX_W = 4,
    parameter int PAL_W = 4
) (
    input  logic                     clk_24M,
    input  logic                     RES,
    input  logic                     PIX_CE,
    input  logic                     HRST,
    input  logic                     LOAD,
    input  logic [8*PIX_W-1:0]       ROM_D,
    input  logic [7:0]               COL,
    input  logic [2:0]               Z,
    input  logic                     FLIPX_EN,
    input  logic                     BLANK,
    output logic [PAL_W+PIX_W-1:0]   DOUT,
    output logic                     TRANSP
);

    localparam int ROW_W = 8 * PIX_W;

    // Staging buffer, written by LOAD at any time.
    logic [ROW_W-1:0]       r_stage_data;
    logic [PAL_W-1:0]       r_stage_pal;
    logic [2:0]             r_stage_z;
    // Tile window: PREV is the tile being left, CUR the tile being entered.
    // Only CUR's scroll value is ever used, so PREV carries none.
    logic [ROW_W-1:0]       r_cur_data;
    logic [PAL_W-1:0]       r_cur_pal;
    logic [2:0]             r_cur_z;
    logic [ROW_W-1:0]       r_prev_data;
    logic [PAL_W-1:0]       r_prev_pal;
    logic [2:0]             r_ph;
    logic [PAL_W+PIX_W-1:0] r_dout;
    logic                   r_transp;

    logic [3:0]             w_idx;
    logic                   w_from_cur;
    logic [2:0]             w_pos;
    logic [2:0]             w_rd_pos;
    logic [ROW_W-1:0]       w_src_data;
    logic [PAL_W-1:0]       w_src_pal;
    logic [PIX_W-1:0]       w_pix;

    // Pixel k of a row sits at the top of the word for k=0 (leftmost).
    function automatic logic [PIX_W-1:0] get_pix(input logic [ROW_W-1:0] data,
                                                 input logic [2:0]       pos);
        int base;
        base = ROW_W - 1 - PIX_W * int'(pos);
        return data[base -: PIX_W];
    endfunction

    // The scrolled window spans PREV (index 0..7) and CUR (index 8..14).
    assign w_idx      = {1'b0, r_ph} + {1'b0, r_cur_z};
    assign w_from_cur = w_idx[3];
    assign w_pos      = w_idx[2:0];
    assign w_src_data = w_from_cur ? r_cur_data : r_prev_data;
    assign w_src_pal  = w_from_cur ? r_cur_pal  : r_prev_pal;

`ifdef TILE_HFLIP_EN
    logic r_stage_flip;
    logic r_cur_flip;
    logic r_prev_flip;
    logic w_src_flip;
    logic w_unused;

    assign w_src_flip = w_from_cur ? r_cur_flip : r_prev_flip;
    assign w_rd_pos   = (FLIPX_EN && w_src_flip) ? (3'd7 - w_pos) : w_pos;
    assign w_unused   = ^COL;

    always_ff @(posedge clk_24M or posedge RES) begin
        if (RES) begin
            r_stage_flip <= 1'b0;
            r_cur_flip   <= 1'b0;
            r_prev_flip  <= 1'b0;
        end else begin
            if (LOAD)
                r_stage_flip <= COL[1];
            if (PIX_CE && !HRST && r_ph == 3'd7) begin
                r_prev_flip <= r_cur_flip;
                r_cur_flip  <= r_stage_flip;
            end
        end
    end
`else
    logic w_unused;

    assign w_rd_pos = w_pos;
    assign w_unused = ^{COL, FLIPX_EN};
`endif

    assign w_pix = get_pix(w_src_data, w_rd_pos);

    // NOTE: every register here, including the tile buffers, is cleared by RES
    // so a reset mid-line yields transparent output until two tiles reload;
    // all state updates use non-blocking assignments so pre-edge values are
    // seen consistently (a transfer on the same edge as LOAD takes the old
    // STAGE contents).
    always_ff @(posedge clk_24M or posedge RES) begin
        if (RES) begin
            r_stage_data <= '0;
            r_stage_pal  <= '0;
            r_stage_z    <= '0;
            r_cur_data   <= '0;
            r_cur_pal    <= '0;
            r_cur_z      <= '0;
            r_prev_data  <= '0;
            r_prev_pal   <= '0;
            r_ph         <= '0;
            r_dout       <= '0;
            r_transp     <= 1'b1;
        end else begin
            if (LOAD) begin
                r_stage_data <= ROM_D;
                r_stage_pal  <= COL[7 -: PAL_W];
                r_stage_z    <= Z;
            end
            if (PIX_CE) begin
                r_dout   <= BLANK ? '0 : {w_src_pal, w_pix};
                r_transp <= BLANK | (w_pix == '0);
                if (!HRST) begin
                    r_ph <= r_ph + 3'd1;
                    if (r_ph == 3'd7) begin
                        r_prev_data <= r_cur_data;
                        r_prev_pal  <= r_cur_pal;
                        r_cur_data  <= r_stage_data;
                        r_cur_pal   <= r_stage_pal;
                        r_cur_z     <= r_stage_z;
                    end
                end
            end
            // Line start wins over the phase increment and blocks the transfer.
            if (HRST)
                r_ph <= 3'd0;
        end
    end

    assign DOUT   = r_dout;
    assign TRANSP = r_transp;

endmodule
